// File: rtl/soc_interrupt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | soc_interrupt_pkg                                                     |
// | Shared types and constants for the core-side interrupt handler.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package soc_interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } int_handler_state_t;

    localparam logic [1:0] c_CSR_MSTATUS = 2'd0;
    localparam logic [1:0] c_CSR_MTVEC   = 2'd1;
    localparam logic [1:0] c_CSR_MEPC    = 2'd2;
    localparam logic [1:0] c_CSR_MCAUSE  = 2'd3;

    localparam int unsigned c_MSTATUS_MIE_BIT  = 3;
    localparam int unsigned c_MSTATUS_MPIE_BIT = 7;

    localparam logic c_MTVEC_MODE_DIRECT   = 1'b0;
    localparam logic c_MTVEC_MODE_VECTORED = 1'b1;

    // mtvec bit 1 is hardwired to zero; mepc is always word aligned.
    localparam logic [31:0] c_MTVEC_WMASK = 32'hFFFF_FFFD;
    localparam logic [31:0] c_PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage
`default_nettype wire

// File: rtl/SoC_InterruptBus.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | SoC_InterruptBus                                                      |
// | Prioritised request / acknowledge link between controller and core.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface SoC_InterruptBus;
    logic       irq;
    logic [4:0] irq_id;
    logic       irq_ack;
    logic [4:0] irq_ack_id;

    modport Handler (
        input  irq,
        input  irq_id,
        output irq_ack,
        output irq_ack_id
    );

    modport Controller (
        output irq,
        output irq_id,
        input  irq_ack,
        input  irq_ack_id
    );
endinterface
`default_nettype wire

// File: rtl/soc_trap_csr_file.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | soc_trap_csr_file                                                     |
// | Machine trap CSRs with hardware-over-software write merge and read mux.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module soc_trap_csr_file
    import soc_interrupt_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        trap_take,
    input  logic [31:0] trap_epc,
    input  logic [4:0]  trap_id,
    input  logic        mret_exec,
    input  logic        csr_we,
    input  logic [1:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [31:0] mret_target,
    output logic [31:0] mtvec_base,
    output logic        mtvec_mode,
    output logic        mie
);

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic        r_mcause_irq;
    logic [4:0]  r_mcause_id;

    logic        w_mie_next;
    logic        w_mpie_next;
    logic [31:0] w_mtvec_next;
    logic [31:0] w_mepc_next;
    logic        w_mcause_irq_next;
    logic [4:0]  w_mcause_id_next;
    logic [31:0] w_mstatus;

    logic w_wr_mstatus;
    logic w_wr_mtvec;
    logic w_wr_mepc;
    logic w_wr_mcause;

    assign w_wr_mstatus = csr_we && (csr_addr == c_CSR_MSTATUS);
    assign w_wr_mtvec   = csr_we && (csr_addr == c_CSR_MTVEC);
    assign w_wr_mepc    = csr_we && (csr_addr == c_CSR_MEPC);
    assign w_wr_mcause  = csr_we && (csr_addr == c_CSR_MCAUSE);

    // Trap entry outranks mret, and both outrank software on the fields they touch.
    always_comb begin
        w_mie_next        = r_mie;
        w_mpie_next       = r_mpie;
        w_mtvec_next      = r_mtvec;
        w_mepc_next       = r_mepc;
        w_mcause_irq_next = r_mcause_irq;
        w_mcause_id_next  = r_mcause_id;

        if (trap_take) begin
            w_mie_next        = 1'b0;
            w_mpie_next       = r_mie;
            w_mepc_next       = trap_epc & c_PC_ALIGN_MASK;
            w_mcause_irq_next = 1'b1;
            w_mcause_id_next  = trap_id;
        end else begin
            if (mret_exec) begin
                w_mie_next  = r_mpie;
                w_mpie_next = 1'b1;
            end else if (w_wr_mstatus) begin
                w_mie_next  = csr_wdata[c_MSTATUS_MIE_BIT];
                w_mpie_next = csr_wdata[c_MSTATUS_MPIE_BIT];
            end
            if (w_wr_mepc) begin
                w_mepc_next = csr_wdata & c_PC_ALIGN_MASK;
            end
            if (w_wr_mcause) begin
                w_mcause_irq_next = csr_wdata[31];
                w_mcause_id_next  = csr_wdata[4:0];
            end
        end

        if (w_wr_mtvec) begin
            w_mtvec_next = csr_wdata & c_MTVEC_WMASK;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_mtvec      <= '0;
            r_mepc       <= '0;
            r_mcause_irq <= 1'b0;
            r_mcause_id  <= '0;
        end else begin
            r_mie        <= w_mie_next;
            r_mpie       <= w_mpie_next;
            r_mtvec      <= w_mtvec_next;
            r_mepc       <= w_mepc_next;
            r_mcause_irq <= w_mcause_irq_next;
            r_mcause_id  <= w_mcause_id_next;
        end
    end

    always_comb begin
        w_mstatus                     = '0;
        w_mstatus[c_MSTATUS_MIE_BIT]  = r_mie;
        w_mstatus[c_MSTATUS_MPIE_BIT] = r_mpie;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            c_CSR_MSTATUS: csr_rdata = w_mstatus;
            c_CSR_MTVEC:   csr_rdata = r_mtvec;
            c_CSR_MEPC:    csr_rdata = r_mepc;
            c_CSR_MCAUSE:  csr_rdata = {r_mcause_irq, 26'b0, r_mcause_id};
            default:       csr_rdata = '0;
        endcase
    end

    assign mret_target = r_mepc;
    assign mtvec_base  = {r_mtvec[31:2], 2'b00};
    assign mtvec_mode  = r_mtvec[0];
    assign mie         = r_mie;

endmodule
`default_nettype wire

// File: rtl/soc_interrupt_handler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | soc_interrupt_handler                                                 |
// | Samples bus requests, raises core traps and acknowledges serviced IDs.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module soc_interrupt_handler
    import soc_interrupt_pkg::*;
(
    input  logic                    clk,
    input  logic                    res,
    SoC_InterruptBus.Handler        int_bus,
    output logic                    trap_req,
    output logic [31:0]             trap_target,
    input  logic                    trap_accept,
    input  logic [31:0]             epc,
    input  logic                    mret_exec,
    output logic [31:0]             mret_target,
    input  logic                    csr_we,
    input  logic [1:0]              csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata
);

    int_handler_state_t r_state;
    int_handler_state_t w_state_next;
    logic [4:0]         r_pend_id;
    logic               w_latch_id;
    logic               w_trap_take;

    logic [31:0]        w_mtvec_base;
    logic               w_mtvec_mode;
    logic               w_mie;

    soc_trap_csr_file u_csr (
        .clk         (clk),
        .res         (res),
        .trap_take   (w_trap_take),
        .trap_epc    (epc),
        .trap_id     (r_pend_id),
        .mret_exec   (mret_exec),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .mret_target (mret_target),
        .mtvec_base  (w_mtvec_base),
        .mtvec_mode  (w_mtvec_mode),
        .mie         (w_mie)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state   <= IDLE;
            r_pend_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_id) begin
                r_pend_id <= int_bus.irq_id;
            end
        end
    end

    // pend_id is captured only on IDLE->REQ so a later, higher ID cannot retarget a pending trap.
    always_comb begin
        w_state_next = r_state;
        w_latch_id   = 1'b0;
        w_trap_take  = 1'b0;
        case (r_state)
            IDLE: begin
                if (int_bus.irq && w_mie) begin
                    w_latch_id   = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (trap_accept) begin
                    w_trap_take  = 1'b1;
                    w_state_next = ACK;
                end else if (!int_bus.irq || !w_mie) begin
                    w_state_next = IDLE;
                end
            end
            ACK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign trap_req    = (r_state == REQ);
    assign trap_target = (w_mtvec_mode == c_MTVEC_MODE_VECTORED)
                       ? (w_mtvec_base + {25'b0, r_pend_id, 2'b00})
                       : w_mtvec_base;

    assign int_bus.irq_ack    = (r_state == ACK);
    assign int_bus.irq_ack_id = (r_state == ACK) ? r_pend_id : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_soc_interrupt_handler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_soc_interrupt_handler                                              |
// | Directed scenarios with an ack-ID scoreboard.                         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_soc_interrupt_handler;

    logic        clk = 1'b0;
    logic        res;
    logic        trap_req;
    logic [31:0] trap_target;
    logic        trap_accept;
    logic [31:0] epc;
    logic        mret_exec;
    logic [31:0] mret_target;
    logic        csr_we;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] exp_ack_q[$];

    always #5 clk = ~clk;

    SoC_InterruptBus bus ();

    soc_interrupt_handler dut (
        .clk         (clk),
        .res         (res),
        .int_bus     (bus),
        .trap_req    (trap_req),
        .trap_target (trap_target),
        .trap_accept (trap_accept),
        .epc         (epc),
        .mret_exec   (mret_exec),
        .mret_target (mret_target),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [1:0] a, input logic [31:0] e);
        csr_addr = a;
        #1;
        check_eq(tag, csr_rdata, e);
    endtask

    // Every ack seen on the bus must match the oldest accepted trap ID.
    always @(negedge clk) begin
        if (bus.irq_ack === 1'b1) begin
            if (exp_ack_q.size() > 0) begin
                check_eq("sb_ack_id", {27'b0, bus.irq_ack_id}, {27'b0, exp_ack_q.pop_front()});
            end else begin
                check_eq("sb_spurious_ack", {31'b0, bus.irq_ack}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        res         = 1'b1;
        trap_accept = 1'b0;
        epc         = '0;
        mret_exec   = 1'b0;
        csr_we      = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        bus.irq     = 1'b0;
        bus.irq_id  = '0;
        repeat (2) tick();
        res = 1'b0;

        check_eq("rst_trap_req", {31'b0, trap_req}, 32'h0);
        check_eq("rst_irq_ack", {31'b0, bus.irq_ack}, 32'h0);
        check_eq("rst_ack_id", {27'b0, bus.irq_ack_id}, 32'h0);
        check_eq("rst_target", trap_target, 32'h0);
        csr_chk("rst_mstatus", 2'd0, 32'h0);

        // Direct-mode trap
        csr_wr(2'd1, 32'h0000_1000);
        csr_wr(2'd0, 32'h0000_0008);
        bus.irq    = 1'b1;
        bus.irq_id = 5'd5;
        tick();
        check_eq("dir_trap_req", {31'b0, trap_req}, 32'h1);
        check_eq("dir_target", trap_target, 32'h0000_1000);
        trap_accept = 1'b1;
        epc         = 32'h0000_2006;
        exp_ack_q.push_back(5'd5);
        tick();
        trap_accept = 1'b0;
        bus.irq     = 1'b0;
        check_eq("dir_ack", {31'b0, bus.irq_ack}, 32'h1);
        check_eq("dir_ack_id", {27'b0, bus.irq_ack_id}, 32'h5);
        check_eq("dir_req_drop", {31'b0, trap_req}, 32'h0);
        tick();
        check_eq("dir_ack_one_cycle", {31'b0, bus.irq_ack}, 32'h0);
        csr_chk("dir_mepc", 2'd2, 32'h0000_2004);
        csr_chk("dir_mcause", 2'd3, 32'h8000_0005);
        csr_chk("dir_mstatus", 2'd0, 32'h0000_0080);
        check_eq("dir_mret_target", mret_target, 32'h0000_2004);

        mret_exec = 1'b1;
        tick();
        mret_exec = 1'b0;
        csr_chk("mret_mstatus", 2'd0, 32'h0000_0088);

        // Vectored trap, plus no re-latch of pend_id while in REQ
        csr_wr(2'd1, 32'h0000_1003);
        csr_chk("vec_mtvec_rd", 2'd1, 32'h0000_1001);
        bus.irq    = 1'b1;
        bus.irq_id = 5'd3;
        tick();
        check_eq("vec_target", trap_target, 32'h0000_100C);
        bus.irq_id = 5'd7;
        tick();
        check_eq("vec_no_relatch", trap_target, 32'h0000_100C);
        trap_accept = 1'b1;
        epc         = 32'h0000_3000;
        exp_ack_q.push_back(5'd3);
        tick();
        trap_accept = 1'b0;
        bus.irq     = 1'b0;
        check_eq("vec_ack_id", {27'b0, bus.irq_ack_id}, 32'h3);
        tick();
        mret_exec = 1'b1;
        tick();
        mret_exec = 1'b0;

        // Withdrawal
        bus.irq    = 1'b1;
        bus.irq_id = 5'd7;
        tick();
        check_eq("wd_target", trap_target, 32'h0000_101C);
        bus.irq = 1'b0;
        tick();
        check_eq("wd_trap_req", {31'b0, trap_req}, 32'h0);
        check_eq("wd_no_ack", {31'b0, bus.irq_ack}, 32'h0);
        tick();
        check_eq("wd_no_ack2", {31'b0, bus.irq_ack}, 32'h0);
        csr_chk("wd_mepc", 2'd2, 32'h0000_3000);
        csr_chk("wd_mcause", 2'd3, 32'h8000_0003);

        // Masking
        csr_wr(2'd0, 32'h0);
        bus.irq    = 1'b1;
        bus.irq_id = 5'd4;
        bad = 0;
        repeat (10) begin
            tick();
            if (trap_req !== 1'b0) bad++;
        end
        check_eq("mask_hold", bad, 32'h0);
        csr_wr(2'd0, 32'h0000_0008);
        check_eq("mask_wr_plus1", {31'b0, trap_req}, 32'h0);
        tick();
        check_eq("mask_wr_plus2", {31'b0, trap_req}, 32'h1);
        check_eq("mask_target", trap_target, 32'h0000_1010);

        // Collision: accept + mret + mstatus write in one cycle
        csr_wr(2'd0, 32'h0000_0088);
        check_eq("col_still_req", {31'b0, trap_req}, 32'h1);
        trap_accept = 1'b1;
        mret_exec   = 1'b1;
        csr_we      = 1'b1;
        csr_addr    = 2'd0;
        csr_wdata   = 32'h0000_0088;
        epc         = 32'h0000_4002;
        exp_ack_q.push_back(5'd4);
        tick();
        trap_accept = 1'b0;
        mret_exec   = 1'b0;
        csr_we      = 1'b0;
        bus.irq     = 1'b0;
        check_eq("col_ack_id", {27'b0, bus.irq_ack_id}, 32'h4);
        csr_chk("col_mstatus", 2'd0, 32'h0000_0080);
        csr_chk("col_mepc", 2'd2, 32'h0000_4000);
        csr_chk("col_mcause", 2'd3, 32'h8000_0004);
        tick();

        // Reset during ACK
        csr_wr(2'd0, 32'h0000_0008);
        csr_wr(2'd1, 32'h0000_2000);
        bus.irq    = 1'b1;
        bus.irq_id = 5'd9;
        tick();
        check_eq("rack_target", trap_target, 32'h0000_2000);
        trap_accept = 1'b1;
        epc         = 32'h0000_5000;
        exp_ack_q.push_back(5'd9);
        tick();
        trap_accept = 1'b0;
        check_eq("rack_in_ack", {31'b0, bus.irq_ack}, 32'h1);
        res = 1'b1;
        tick();
        res = 1'b0;
        check_eq("rack_trap_req", {31'b0, trap_req}, 32'h0);
        check_eq("rack_irq_ack", {31'b0, bus.irq_ack}, 32'h0);
        check_eq("rack_ack_id", {27'b0, bus.irq_ack_id}, 32'h0);
        check_eq("rack_target0", trap_target, 32'h0);
        check_eq("rack_mret_target", mret_target, 32'h0);
        csr_chk("rack_mstatus", 2'd0, 32'h0);
        csr_chk("rack_mtvec", 2'd1, 32'h0);
        csr_chk("rack_mcause", 2'd3, 32'h0);
        tick();
        check_eq("rack_no_retrigger", {31'b0, trap_req}, 32'h0);
        bus.irq = 1'b0;
        tick();

        check_eq("sb_empty", exp_ack_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
